demux_8ch: RTL
==============

Name: demux_8ch

Overview:
Registered 1-to-8 demultiplexer, the inverse of the team's 8:1 `mux` block. It accepts a data word plus a 4-bit channel select over a valid/ready handshake and delivers the word to one of eight output holding registers. Each channel holds its word until the downstream consumer acknowledges it. The block sits between a single producer and eight independent consumers, and can route either by explicit select or by an internal round-robin pointer.

Parameters:
DW, 4, data width of input and of each output channel
CW, 8, width of the delivered-transfer counter

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
din  input  DW  input data word
c  input  4  channel select; values 0..7 valid, 8..15 invalid
in_valid  input  1  producer has a word on din/c
in_ready  output  1  block accepts this cycle (combinational)
auto_mode  input  1  1 = ignore c, route to internal pointer
err_clr  input  1  clears sticky error flag
out0..out7  output  DW each  channel holding registers
out_valid  output  8  bit k = out<k> holds an unacknowledged word
out_ack  input  8  bit k = consumer k takes out<k> this cycle
err  output  1  sticky: an invalid select was accepted
ptr  output  3  current round-robin pointer
xfer_cnt  output  CW  count of delivered words

Behaviour:
- Reset (rst_n low, asynchronous): out0..out7=0, out_valid=0, err=0, ptr=0, xfer_cnt=0. in_ready is forced 0 while rst_n is low.
- Target channel: tgt = ptr if auto_mode=1, otherwise c[2:0]. The target is invalid only when auto_mode=0 and c>=8.
- in_ready, valid target: in_ready = ~out_valid[tgt] | out_ack[tgt]. An ack on the target in the same cycle frees the slot, so there is no bubble.
- in_ready, invalid target: in_ready=1 (the word is sunk).
- Accept occurs on a posedge with in_valid & in_ready. For a valid target:
  - out<tgt> <= din and out_valid[tgt] <= 1, so the word is visible one cycle after accept.
  - xfer_cnt increments, wrapping from 2^CW-1 to 0.
  - if auto_mode=1, ptr increments, wrapping 7 -> 0.
- Accept with an invalid target: data is discarded, err <= 1, and out*, out_valid, ptr and xfer_cnt are unchanged.
- Ack: if out_valid[k] & out_ack[k] and there is no same-cycle write to k, then out_valid[k] <= 0. out<k> retains its value (not cleared).
- Ack on k while out_valid[k]=0: ignored.
- Simultaneous ack and write to the same channel: the write wins. out_valid stays 1 and out<k> takes the new din.
- Writes to one channel and acks on other channels in the same cycle are independent; any number of acks may occur per cycle.
- err_clr: err <= 0. If err_clr and an invalid accept occur in the same cycle, set wins and err=1.
- ptr advances only on valid accepts in auto mode. It is held (not reset) when auto_mode toggles, and it is not altered by manual-mode transfers.
- No transfer occurs while in_valid=0, regardless of c.
- Reset asserted mid-operation: all held words and flags are lost immediately. No partial state survives deassertion. Deassertion is assumed synchronized externally.

Test Plan:
1. Reset then manual routing: with out_ack=0, drive c=3,din=5 then c=0,din=9 on consecutive cycles. Required: out3=5 and out_valid=8'h08 one cycle after the first accept, then out0=9 and out_valid=8'h09; xfer_cnt=2; err=0.
2. Backpressure: with out_valid[3]=1 and out_ack=0, drive c=3,din=A. Required: in_ready=0 and out3 unchanged. Pulse out_ack[3] with in_valid still high. Required: in_ready=1 that cycle, next cycle out3=A and out_valid[3]=1.
3. Ack without write: with out_valid[6]=1, pulse out_ack[6] with in_valid=0. Required: out_valid[6]=0 next cycle and out6 retains its data.
4. Invalid select: c=12,din=F,in_valid=1. Required: in_ready=1, err=1 next cycle, out_valid and xfer_cnt unchanged. Assert err_clr together with a second c=9 accept. Required: err stays 1. err_clr alone: err=0.
5. Auto mode wrap: auto_mode=1, acks tied high, 10 consecutive accepts with din=0..9. Required: words land in channels 0,1,..,7,0,1, ptr=2 and xfer_cnt=10 afterwards, and c is ignored throughout.
6. Async reset mid-stream: assert rst_n=0 between clock edges with several channels valid. Required: out_valid=0, err=0, ptr=0, xfer_cnt=0 and in_ready=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demux_8ch.sv
// Registered 1-to-8 demultiplexer with per-channel holding registers,
// valid/ack release, round-robin auto routing and a sticky select error.
module demux_8ch #(
   parameter int DW = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic [3:0]    c,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          auto_mode,
   input  logic          err_clr,
   output logic [DW-1:0] out0,
   output logic [DW-1:0] out1,
   output logic [DW-1:0] out2,
   output logic [DW-1:0] out3,
   output logic [DW-1:0] out4,
   output logic [DW-1:0] out5,
   output logic [DW-1:0] out6,
   output logic [DW-1:0] out7,
   output logic [7:0]    out_valid,
   input  logic [7:0]    out_ack,
   output logic          err,
   output logic [2:0]    ptr,
   output logic [CW-1:0] xfer_cnt
);

   logic [DW-1:0] data_q [8];
   logic [DW-1:0] data_d [8];
   logic [7:0]    vld_q, vld_d;
   logic          err_q, err_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    tgt;
   logic          tgt_ok;
   logic          acc;

   always_comb begin
      tgt      = auto_mode ? ptr_q : c[2:0];
      tgt_ok   = auto_mode | ~c[3];
      // an ack on the target frees the slot in the same cycle
      in_ready = rst_n & (~tgt_ok | ~vld_q[tgt] | out_ack[tgt]);
      acc      = in_valid & in_ready;
      data_d   = data_q;
      vld_d    = vld_q & ~out_ack;
      err_d    = err_q & ~err_clr;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      if (acc & tgt_ok) begin
         data_d[tgt] = din;
         vld_d[tgt]  = 1'b1;
         cnt_d       = cnt_q + CW'(1);
         if (auto_mode)
            ptr_d = ptr_q + 3'd1;
      end
      if (acc & ~tgt_ok)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++)
            data_q[k] <= '0;
         vld_q <= '0;
         err_q <= 1'b0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < 8; k++)
            data_q[k] <= data_d[k];
         vld_q <= vld_d;
         err_q <= err_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   assign out0      = data_q[0];
   assign out1      = data_q[1];
   assign out2      = data_q[2];
   assign out3      = data_q[3];
   assign out4      = data_q[4];
   assign out5      = data_q[5];
   assign out6      = data_q[6];
   assign out7      = data_q[7];
   assign out_valid = vld_q;
   assign err       = err_q;
   assign ptr       = ptr_q;
   assign xfer_cnt  = cnt_q;

endmodule
